// File: rtl/umi_arb_pkg.sv
// Shared types and constants for the UMI request arbiter slice.
// Opcode lives in packet[7:0]; only the read opcode matters to the arbiter.
package umi_arb_pkg;

    localparam int UMI_PKT_W = 256;
    localparam int UMI_OPC_W = 8;

    localparam logic [UMI_OPC_W-1:0] UMI_OPC_WRITE = 8'h01;
    localparam logic [UMI_OPC_W-1:0] UMI_OPC_READ  = 8'h08;

    // Requester ID width; never narrower than one bit.
    function automatic int clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/umi_arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding reads.
// Pushes into a full FIFO and pops from an empty one are ignored.
module umi_arb_id_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/umi_unpack.sv
// Minimal UMI packet decoder: flags read requests from the opcode field.
module umi_unpack
    import umi_arb_pkg::*;
(
    input  logic [UMI_PKT_W-1:0] packet,
    output logic                 cmd_read
);

    logic unused_fields;

    assign cmd_read      = (packet[UMI_OPC_W-1:0] == UMI_OPC_READ);
    assign unused_fields = ^packet[UMI_PKT_W-1:UMI_OPC_W];

endmodule

// File: rtl/umi_req_arbiter.sv
// Round-robin arbiter sharing one UMI request port among N requesters,
// routing in-order read responses back to the requester that issued them.
module umi_req_arbiter
    import umi_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N*UMI_PKT_W-1:0] req_packet,
    input  logic [N-1:0]           req_valid,
    output logic [N-1:0]           req_ready,
    output logic [N*UMI_PKT_W-1:0] resp_packet,
    output logic [N-1:0]           resp_valid,
    input  logic [N-1:0]           resp_ready,
    output logic [UMI_PKT_W-1:0]   umi_out_packet,
    output logic                   umi_out_valid,
    input  logic                   umi_out_ready,
    input  logic [UMI_PKT_W-1:0]   umi_in_packet,
    input  logic                   umi_in_valid,
    output logic                   umi_in_ready,
    output logic                   err_unexpected
);

    localparam int ID_W  = clog2(N);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [N-1:0]         is_read;
    logic [N-1:0]         eligible;
    logic [ID_W-1:0]      last_grant;
    logic [ID_W-1:0]      winner;
    logic                 found;
    logic                 load_ok;
    logic                 grant;
    logic [UMI_PKT_W-1:0] win_pkt;
    logic                 win_is_read;
    int                   idx;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ID_W-1:0]      fifo_head;
    logic [CNT_W-1:0]     unused_fifo_count;
    logic                 head_ready;

    for (genvar g = 0; g < N; g++) begin : g_slice
        umi_unpack u_unpack (
            .packet   (req_packet[g*UMI_PKT_W +: UMI_PKT_W]),
            .cmd_read (is_read[g])
        );
        // Reads need an ID slot; the full flag is the one seen at cycle start.
        assign eligible[g] = req_valid[g] && (!is_read[g] || !fifo_full);
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(last_grant) + 1 + k;
            if (idx >= N) idx = idx - N;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign load_ok = !umi_out_valid || umi_out_ready;
    assign grant   = found && load_ok && !rst;

    always_comb begin
        req_ready   = '0;
        win_pkt     = '0;
        win_is_read = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (winner == ID_W'(i)) begin
                req_ready[i] = grant;
                win_pkt      = req_packet[i*UMI_PKT_W +: UMI_PKT_W];
                win_is_read  = is_read[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            umi_out_valid  <= 1'b0;
            umi_out_packet <= '0;
            last_grant     <= ID_W'(N - 1);
        end else begin
            if (grant) begin
                umi_out_valid  <= 1'b1;
                umi_out_packet <= win_pkt;
                last_grant     <= winner;
            end else if (umi_out_ready) begin
                umi_out_valid  <= 1'b0;
            end
        end
    end

    assign fifo_push = grant && win_is_read;

    umi_arb_id_fifo #(
        .DEPTH (DEPTH),
        .W     (ID_W)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (winner),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

    // Responses go only to the oldest outstanding reader; with no reader
    // the response is left stalled on umi_in rather than dropped.
    always_comb begin
        resp_valid = '0;
        head_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (fifo_head == ID_W'(i)) begin
                resp_valid[i] = umi_in_valid && !fifo_empty && !rst;
                head_ready    = resp_ready[i];
            end
        end
    end

    assign umi_in_ready = !fifo_empty && head_ready && !rst;
    assign fifo_pop     = umi_in_valid && umi_in_ready;
    assign resp_packet  = {N{umi_in_packet}};

    always_ff @(posedge clk) begin
        if (rst) begin
            err_unexpected <= 1'b0;
        end else if (umi_in_valid && fifo_empty) begin
            err_unexpected <= 1'b1;
        end
    end

endmodule

// File: tb/tb_umi_req_arbiter.sv
// Directed bench for umi_req_arbiter: vector table for round-robin writes,
// hand sequences for read routing, FIFO-full stall, backpressure, errors, reset.
module tb_umi_req_arbiter;
    import umi_arb_pkg::*;

    localparam int N = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N*256-1:0]     req_packet;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         resp_ready;
    logic                 umi_out_ready;
    logic [255:0]         umi_in_packet;
    logic                 umi_in_valid;

    logic [N-1:0]         req_ready,   req_ready_2;
    logic [N*256-1:0]     resp_packet, resp_packet_2;
    logic [N-1:0]         resp_valid,  resp_valid_2;
    logic [255:0]         umi_out_packet, umi_out_packet_2;
    logic                 umi_out_valid,  umi_out_valid_2;
    logic                 umi_in_ready,   umi_in_ready_2;
    logic                 err_unexpected, err_unexpected_2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    umi_req_arbiter #(.N(N), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_packet(req_packet), .req_valid(req_valid), .req_ready(req_ready),
        .resp_packet(resp_packet), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .umi_out_packet(umi_out_packet), .umi_out_valid(umi_out_valid),
        .umi_out_ready(umi_out_ready),
        .umi_in_packet(umi_in_packet), .umi_in_valid(umi_in_valid),
        .umi_in_ready(umi_in_ready), .err_unexpected(err_unexpected)
    );

    umi_req_arbiter #(.N(N), .DEPTH(2)) dut_d2 (
        .clk(clk), .rst(rst),
        .req_packet(req_packet), .req_valid(req_valid), .req_ready(req_ready_2),
        .resp_packet(resp_packet_2), .resp_valid(resp_valid_2), .resp_ready(resp_ready),
        .umi_out_packet(umi_out_packet_2), .umi_out_valid(umi_out_valid_2),
        .umi_out_ready(umi_out_ready),
        .umi_in_packet(umi_in_packet), .umi_in_valid(umi_in_valid),
        .umi_in_ready(umi_in_ready_2), .err_unexpected(err_unexpected_2)
    );

    function automatic logic [255:0] mk_pkt(input logic [7:0] opc, input int src, input int tag);
        logic [255:0] p;
        p = '0;
        p[7:0]     = opc;
        p[15:8]    = 8'(src);
        p[31:16]   = 16'(tag);
        p[255:224] = 32'hA5A5_0000 ^ 32'(tag);
        return p;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_reqs(input logic [3:0] rv, input logic [3:0] rd, input int tag);
        for (int i = 0; i < N; i++)
            req_packet[i*256 +: 256] = mk_pkt(rd[i] ? UMI_OPC_READ : UMI_OPC_WRITE, i, tag);
        req_valid = rv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        req_valid     = '0;
        req_packet    = '0;
        umi_out_ready = 1'b0;
        umi_in_valid  = 1'b0;
        umi_in_packet = '0;
        resp_ready    = '1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] rv;
        logic       out_rdy;
        logic [3:0] exp_rr;
        logic       exp_vld;
        int         exp_src;
        int         exp_tag;
    } vec_t;

    vec_t       vecs [12];
    logic [3:0] seq_b [6];

    initial begin
        // rv, out_rdy | req_ready, out_valid after edge, source and row of held packet
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0, 0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1, 1};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2, 2};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 3, 3};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0, 4};
        vecs[5]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 1, 5};
        vecs[6]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 3, 6};
        vecs[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0, 0};
        vecs[8]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 0, 8};
        vecs[9]  = '{4'b0110, 1'b0, 4'b0000, 1'b1, 0, 8};
        vecs[10] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 1, 10};
        vecs[11] = '{4'b0110, 1'b1, 4'b0100, 1'b1, 2, 11};

        seq_b[0] = 4'b0010;
        seq_b[1] = 4'b1000;
        seq_b[2] = 4'b0010;
        seq_b[3] = 4'b1000;
        seq_b[4] = 4'b1000;
        seq_b[5] = 4'b1000;

        // Reset values
        do_reset();
        #1;
        check("rst_out_valid", 256'(umi_out_valid), 256'(0));
        check("rst_out_packet", umi_out_packet, '0);
        check("rst_req_ready", 256'(req_ready), 256'(0));
        check("rst_resp_valid", 256'(resp_valid), 256'(0));
        check("rst_in_ready", 256'(umi_in_ready), 256'(0));
        check("rst_err", 256'(err_unexpected), 256'(0));

        // Round-robin writes, gaps and backpressure
        for (int r = 0; r < 12; r++) begin
            set_reqs(vecs[r].rv, 4'b0000, r);
            umi_out_ready = vecs[r].out_rdy;
            #1;
            check($sformatf("rr_req_ready_row%0d", r), 256'(req_ready), 256'(vecs[r].exp_rr));
            tick();
            check($sformatf("rr_out_valid_row%0d", r), 256'(umi_out_valid), 256'(vecs[r].exp_vld));
            if (vecs[r].exp_vld)
                check($sformatf("rr_out_packet_row%0d", r), umi_out_packet,
                      mk_pkt(UMI_OPC_WRITE, vecs[r].exp_src, vecs[r].exp_tag));
        end

        // Read from 2 then 0; responses routed in order
        do_reset();
        umi_out_ready = 1'b1;
        set_reqs(4'b0100, 4'b0100, 200);
        #1;
        check("rd_grant2", 256'(req_ready), 256'(4'b0100));
        tick();
        check("rd_out2", umi_out_packet, mk_pkt(UMI_OPC_READ, 2, 200));
        set_reqs(4'b0001, 4'b0001, 201);
        #1;
        check("rd_grant0", 256'(req_ready), 256'(4'b0001));
        tick();
        check("rd_out0", umi_out_packet, mk_pkt(UMI_OPC_READ, 0, 201));
        req_valid     = '0;
        resp_ready    = 4'b0000;
        umi_in_valid  = 1'b1;
        umi_in_packet = mk_pkt(8'h0A, 7, 300);
        #1;
        check("ra_resp_valid", 256'(resp_valid), 256'(4'b0100));
        check("ra_in_ready_blocked", 256'(umi_in_ready), 256'(0));
        resp_ready = 4'b1111;
        #1;
        check("ra_in_ready", 256'(umi_in_ready), 256'(1));
        check("ra_resp_packet", resp_packet[2*256 +: 256], mk_pkt(8'h0A, 7, 300));
        tick();
        umi_in_packet = mk_pkt(8'h0A, 7, 301);
        #1;
        check("rb_resp_valid", 256'(resp_valid), 256'(4'b0001));
        check("rb_in_ready", 256'(umi_in_ready), 256'(1));
        tick();
        umi_in_valid = 1'b0;
        #1;
        check("resp_idle", 256'(resp_valid), 256'(0));
        check("resp_no_err", 256'(err_unexpected), 256'(0));

        // DEPTH=2: third read from 1 stalls while writes from 3 proceed
        do_reset();
        umi_out_ready = 1'b1;
        set_reqs(4'b1010, 4'b0010, 100);
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("full_grant_c%0d", c), 256'(req_ready_2), 256'(seq_b[c]));
            tick();
        end
        check("full_out_write3", umi_out_packet_2, mk_pkt(UMI_OPC_WRITE, 3, 100));
        umi_in_valid  = 1'b1;
        umi_in_packet = mk_pkt(8'h0A, 1, 400);
        #1;
        check("full_resp_valid", 256'(resp_valid_2), 256'(4'b0010));
        check("full_in_ready", 256'(umi_in_ready_2), 256'(1));
        check("full_still_blocked", 256'(req_ready_2), 256'(4'b1000));
        tick();
        umi_in_valid = 1'b0;
        #1;
        check("full_read_granted", 256'(req_ready_2), 256'(4'b0010));
        tick();
        check("full_out_read1", umi_out_packet_2, mk_pkt(UMI_OPC_READ, 1, 100));

        // Output backpressure holds packet stable
        do_reset();
        umi_out_ready = 1'b1;
        set_reqs(4'b0001, 4'b0000, 500);
        tick();
        umi_out_ready = 1'b0;
        set_reqs(4'b1111, 4'b0000, 501);
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp_req_ready_c%0d", c), 256'(req_ready), 256'(0));
            check($sformatf("bp_out_valid_c%0d", c), 256'(umi_out_valid), 256'(1));
            check($sformatf("bp_out_packet_c%0d", c), umi_out_packet, mk_pkt(UMI_OPC_WRITE, 0, 500));
            tick();
        end
        umi_out_ready = 1'b1;
        #1;
        check("bp_release_grant", 256'(req_ready), 256'(4'b0010));
        tick();

        // Unexpected response with empty FIFO
        do_reset();
        umi_in_valid  = 1'b1;
        umi_in_packet = mk_pkt(8'h0A, 0, 600);
        #1;
        check("unexp_in_ready", 256'(umi_in_ready), 256'(0));
        check("unexp_resp_valid", 256'(resp_valid), 256'(0));
        check("unexp_err_before", 256'(err_unexpected), 256'(0));
        tick();
        check("unexp_err_rise", 256'(err_unexpected), 256'(1));
        umi_in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("unexp_err_sticky", 256'(err_unexpected), 256'(1));
        do_reset();
        #1;
        check("unexp_err_cleared", 256'(err_unexpected), 256'(0));

        // Reset with three reads outstanding
        do_reset();
        umi_out_ready = 1'b1;
        set_reqs(4'b0111, 4'b0111, 700);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("mr_grant_c%0d", c), 256'(req_ready), 256'(1 << c));
            tick();
        end
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_out_valid", 256'(umi_out_valid), 256'(0));
        check("mr_out_packet", umi_out_packet, '0);
        umi_in_valid = 1'b1;
        #1;
        check("mr_fifo_empty_resp", 256'(resp_valid), 256'(0));
        check("mr_fifo_empty_ready", 256'(umi_in_ready), 256'(0));
        umi_in_valid = 1'b0;
        set_reqs(4'b1111, 4'b0000, 701);
        #1;
        check("mr_priority0", 256'(req_ready), 256'(4'b0001));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/umi_req_arbiter.md
# umi_req_arbiter

Round-robin arbiter that shares one UMI outbound request port among N requesters and routes read responses back to the requester that issued the read. It sits between several UMI masters (test drivers, CPU-side bridges) and a single UMI target such as the GPIO endpoint, which answers reads in order on its outbound port. Writes are fire-and-forget. Reads are tracked in an in-order ID FIFO so each response returns to its originator.

## Interface
- N, 4, number of requesters (2..16)
- DEPTH, 8, max outstanding reads (power of 2, ≥2)
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- req_packet  input  N*256  requester i packet at bits [i*256 +: 256]
- req_valid  input  N  per-requester request valid
- req_ready  output  N  per-requester accept; one-hot or zero
- resp_packet  output  N*256  copy of umi_in_packet, broadcast to all slices
- resp_valid  output  N  per-requester response valid; one-hot or zero
- resp_ready  input  N  per-requester response ready
- umi_out_packet  output  256  registered packet to target
- umi_out_valid  output  1  registered valid to target
- umi_out_ready  input  1  target ready
- umi_in_packet  input  256  response from target
- umi_in_valid  input  1  response valid
- umi_in_ready  output  1  response accept
- err_unexpected  output  1  sticky: response seen with no outstanding read

## Operation
- Output stage: one register (packet + valid). It can load when `!umi_out_valid || umi_out_ready`.
- Eligibility per requester:
  - req_valid[i] must be high.
  - If the packet decodes as cmd_read (via umi_unpack), the ID FIFO must also be not full, using the full flag at cycle start.
  - Writes and all other opcodes are always eligible.
- Arbitration: round-robin. Search starts at `(last_grant+1) mod N`, and the first eligible requester wins.
  - A blocked read is skipped; a later eligible write may win.
  - last_grant updates only on an actual grant.
- Grant (winner w, output stage able to load):
  - req_ready[w]=1 combinationally in the same cycle.
  - Packet is latched into the output register; umi_out_valid←1.
  - If the packet is a read, push w into the ID FIFO in that cycle.
- If nothing is granted and umi_out_ready is high, umi_out_valid←0.
- Response path (combinational):
  - resp_valid[h] = umi_in_valid && fifo_nonempty, where h is the FIFO head.
  - umi_in_ready = fifo_nonempty && resp_ready[h].
  - Pop the FIFO on the umi_in handshake.
- Response arriving with the FIFO empty:
  - umi_in_ready stays 0; the response is stalled and not dropped.
  - err_unexpected←1 and stays set until rst.
- Simultaneous push and pop: both take effect. Count is unchanged, and a full FIFO stays full that cycle.

## Timing
- Reset values: umi_out_valid=0, umi_out_packet=0, req_ready=0, resp_valid=0, umi_in_ready=0, err_unexpected=0, FIFO empty, last_grant=N-1 (so requester 0 has first priority).
- Request latency: the packet appears on umi_out one cycle after its req_valid&&req_ready handshake.
- Throughput: one packet per cycle while umi_out_ready=1.
- Response path: zero latency.
- Once umi_out_valid is asserted, the packet is held stable until umi_out_ready.
- FIFO count register is $clog2(DEPTH)+1 bits wide; read/write pointers wrap modulo DEPTH.
- rst mid-operation discards the output register and all outstanding IDs. Responses arriving afterwards follow the "FIFO empty" rule above.

## Structure
- Package umi_arb_pkg:
  - UMI_PKT_W=256.
  - Requester ID width function clog2(N).
- Sub-module umi_arb_id_fifo: synchronous FIFO with DEPTH and ID width as parameters, providing push, pop, head, full, empty and count.
- umi_unpack is instantiated per requester slice, using cmd_read only.

## Test plan
- Requesters 0–3 all hold writes continuously with umi_out_ready=1:
  - grants run 0,1,2,3,0,…
  - one packet per cycle; each packet appears one cycle after its grant.
- Requester 2 issues a read, then requester 0 issues a read; the target answers with R_a then R_b:
  - R_a appears on resp_valid[2] only;
  - R_b appears on resp_valid[0] only.
- N=4, DEPTH=2; requester 1 issues 3 reads while requester 3 issues writes, with no responses returned:
  - third read is stalled (req_ready[1]=0);
  - writes from requester 3 are still granted.
  - After one response, the third read is granted on the next cycle.
- umi_out_ready held low for 5 cycles with pending requests:
  - umi_out_packet and umi_out_valid stay stable;
  - all req_ready=0.
- umi_in_valid=1 with the FIFO empty:
  - umi_in_ready=0;
  - err_unexpected rises next cycle and stays high until rst.
- rst asserted while 3 reads are outstanding:
  - next cycle umi_out_valid=0 and FIFO empty;
  - requester 0 has first priority.
